serial_add_ctrl: RTL and testbench

- Bit-serial adder controller built around a single 1-bit full-adder cell (sum = odd parity, carry = majority of a, b, cin).
- Accepts a WIDTH-bit operand pair over a valid/ready handshake.
- Sequences the full adder LSB-first over WIDTH cycles through a registered carry, then presents sum and carry-out on an output valid/ready handshake.
- Used where area matters more than latency; shares one full-adder cell across all bit positions.

---
 rtl/serial_add_pkg.sv | 20 ++
 rtl/fa_bit.sv | 15 +
 rtl/serial_add_ctrl.sv | 158 +++++++++++++++
 tb/tb_serial_add_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and helpers for the bit-serial adder
// Purpose: FSM state encoding, width limit and counter-width helper used by
//          serial_add_ctrl.
// Ports:   none (package).
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MAX_WIDTH = 32;

  // Bit counter width; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/fa_bit.sv
// rtl/fa_bit.sv - combinational 1-bit full adder cell
// Purpose: the single adder cell shared across every bit position.
// Ports:   a, b, cin -> sum (odd parity), carry (majority).
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller around one full-adder cell
// Purpose: accepts a WIDTH-bit operand pair, adds LSB-first over WIDTH cycles
//          through a registered carry, then holds sum/cout until consumed.
// Ports:   clk, rst_n (async, active-low)
//          start_valid/start_ready, a, b, cin : operand handshake
//          done_valid/done_ready, sum, cout   : result handshake
//          busy                               : high while in RUN
// Config:  SERIAL_ADD_SUB_EN adds input sub (1 = compute a - b).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic             rdy_q, rdy_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             fa_sum, fa_carry;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  fa_bit u_fa (
    .a     (a_sr_q[0]),
    .b     (b_sr_q[0]),
    .cin   (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // rdy_q keeps start_ready low until the first clock after reset release.
  // In DONE a new operand pair can ride on the same cycle as the result.
  assign start_ready = ((state_q == IDLE) & rdy_q) |
                       ((state_q == DONE) & done_q & done_ready);
  assign done_valid  = done_q;
  assign busy        = (state_q == RUN);
  assign sum         = sum_q;
  assign cout        = cout_q;

  always_comb begin
    state_d  = state_q;
    rdy_d    = 1'b1;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    sum_d    = sum_q;
    cout_d   = cout_q;

`ifdef SERIAL_ADD_SUB_EN
    // Two's-complement subtract: invert B and force carry-in to 1.
    b_load = sub ? ~b : b;
    c_load = sub ? 1'b1 : cin;
`else
    b_load = b;
    c_load = cin;
`endif

    case (state_q)
      IDLE: begin
        if (start_valid && start_ready) begin
          a_sr_d  = a;
          b_sr_d  = b_load;
          carry_d = c_load;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_sr_d = {fa_sum, sum_sr_q[WIDTH-1:1]};
        carry_d  = fa_carry;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        // First DONE cycle captures the result into the output registers;
        // done_valid follows, so outputs never change while valid is high.
        if (!done_q) begin
          done_d = 1'b1;
          sum_d  = sum_sr_q;
          cout_d = carry_q;
        end else if (done_ready) begin
          done_d = 1'b0;
          if (start_valid) begin
            a_sr_d  = a;
            b_sr_d  = b_load;
            carry_d = c_load;
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rdy_q    <= 1'b0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= rdy_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl (WIDTH=8)
module tb_serial_add_ctrl;

  localparam int W = 8;

  typedef struct packed {
    logic       cout;
    logic [W-1:0] sum;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a, b;
  logic         cin;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif
  logic         done_valid;
  logic         done_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int checks = 0;
  int errors = 0;
  res_t sb_q[$];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub         (sub),
`endif
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .sum         (sum),
    .cout        (cout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input logic s);
    logic [W:0] r;
    if (s) r = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    else   r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    return r;
  endfunction

  // Drive operands at a negedge, wait (bounded) for start_ready, handshake on
  // the next posedge and push the expected result. Returns at posedge+1.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input logic s);
    int n = 0;
    @(negedge clk);
    a = x; b = y; cin = c; start_valid = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
    sub = s;
`endif
    while (!start_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("start_ready_wait", {31'd0, start_ready}, 32'd1);
    @(posedge clk);
    sb_q.push_back(model(x, y, c, s));
    #1 start_valid = 1'b0;
  endtask

  // Count clocks from the handshake edge until done_valid, then check the
  // result against the scoreboard head.
  task automatic wait_done(input string tag);
    int cyc = 0;
    res_t e;
    while (!done_valid && cyc < 40) begin
      @(posedge clk);
      #1 cyc++;
    end
    check({tag, "_latency"}, cyc, W + 1);
    check({tag, "_valid"}, {31'd0, done_valid}, 32'd1);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_nonempty"}, sb_q.size(), 1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_sum"}, {24'd0, sum}, {24'd0, e.sum});
      check({tag, "_cout"}, {31'd0, cout}, {31'd0, e.cout});
    end
  endtask

  task automatic accept();
    @(negedge clk);
    done_ready = 1'b1;
    @(posedge clk);
    #1 done_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] held_sum;
    logic         held_cout;

    rst_n = 1'b0; start_valid = 1'b0; a = '0; b = '0; cin = 1'b0; done_ready = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_start_ready", {31'd0, start_ready}, 0);
    check("rst_done_valid", {31'd0, done_valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_sum", {24'd0, sum}, 0);
    check("rst_cout", {31'd0, cout}, 0);
    rst_n = 1'b1;
    #1 check("rel_start_ready_pre", {31'd0, start_ready}, 0);
    @(posedge clk);
    #1 check("rel_start_ready_post", {31'd0, start_ready}, 1);

    // 5A + 33 = 8D
    start_op(8'h5A, 8'h33, 1'b0, 1'b0);
    check("run_busy", {31'd0, busy}, 1);
    check("run_start_ready", {31'd0, start_ready}, 0);
    wait_done("op5a33");
    accept();

    // FF + 01 = 00 carry 1
    start_op(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done("opff01");
    accept();

    // FF + FF + 1 = FF carry 1, with backpressure
    start_op(8'hFF, 8'hFF, 1'b1, 1'b0);
    wait_done("opffff");
    held_sum = sum; held_cout = cout;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_sum", {24'd0, sum}, {24'd0, held_sum});
      check("bp_cout", {31'd0, cout}, {31'd0, held_cout});
      check("bp_valid", {31'd0, done_valid}, 1);
      check("bp_start_ready", {31'd0, start_ready}, 0);
    end
    accept();
    check("bp_after_valid", {31'd0, done_valid}, 0);
    check("bp_after_start_ready", {31'd0, start_ready}, 1);
    check("bp_after_busy", {31'd0, busy}, 0);

    // Back-to-back: 12 + 34, then 01 + 01 on the done handshake
    start_op(8'h12, 8'h34, 1'b0, 1'b0);
    wait_done("op1234");
    @(negedge clk);
    a = 8'h01; b = 8'h01; cin = 1'b0; start_valid = 1'b1; done_ready = 1'b1;
    #1 check("b2b_start_ready", {31'd0, start_ready}, 1);
    @(posedge clk);
    sb_q.push_back(model(8'h01, 8'h01, 1'b0, 1'b0));
    #1 start_valid = 1'b0; done_ready = 1'b0;
    check("b2b_busy", {31'd0, busy}, 1);
    check("b2b_done_clear", {31'd0, done_valid}, 0);
    wait_done("op0101");
    accept();

    // Reset three cycles into RUN
    start_op(8'h77, 8'h11, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_done_valid", {31'd0, done_valid}, 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_sum", {24'd0, sum}, 0);
    check("mid_rst_cout", {31'd0, cout}, 0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    start_op(8'h10, 8'h20, 1'b0, 1'b0);
    wait_done("op1020");
    accept();

`ifdef SERIAL_ADD_SUB_EN
    start_op(8'h10, 8'h01, 1'b0, 1'b1);
    wait_done("sub1001");
    accept();
    start_op(8'h01, 8'h02, 1'b1, 1'b1);
    wait_done("sub0102");
    accept();
`endif

    check("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
